bit_clock_recovery_v2: RTL and testbench

Parametrised successor to the team's single-channel bit clock recovery. It estimates the bit period of an asynchronous serial `signal` by tracking the minimum valid edge interval, in `clk_300M` cycles. From that estimate it regenerates an edge-aligned recovered clock and samples the data mid-bit. New behaviour over the earlier generation:
- reset
- input synchronisation
- glitch rejection
- lock and timeout detection
- a re-acquire command
- data output

---
 rtl/cdr_pkg.sv | 7 +
 rtl/bit_clock_recovery_v2_if.sv | 13 +
 rtl/sig_edge_sync.sv | 30 +++
 rtl/bit_clock_recovery_v2.sv | 125 ++++++++++++
 tb/tb_bit_clock_recovery_v2.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/cdr_pkg.sv
// cdr_pkg: shared widths and encodings for the bit clock recovery block
package cdr_pkg;
  localparam int CNT_LEN_DEF    = 32;
  localparam int STABLE_LEN_DEF = 8;
  localparam int GLITCH_W       = 16;
  typedef enum logic {MODE_HALF = 1'b0, MODE_FULL = 1'b1} mode_e;
endpackage

// File: rtl/bit_clock_recovery_v2_if.sv
// bit_clock_recovery_v2_if: serial input, control keys and recovery results
// master drives signal/mode/invert_n/clear_n; slave (the recovery core) returns
// clk_rec, bit_period, locked, data_out, data_valid and glitch_cnt
interface bit_clock_recovery_v2_if import cdr_pkg::*; #(parameter int CNT_LEN = CNT_LEN_DEF);
  logic                signal, mode, invert_n, clear_n;
  logic                clk_rec, locked, data_out, data_valid;
  logic [CNT_LEN-1:0]  bit_period;
  logic [GLITCH_W-1:0] glitch_cnt;
  modport master (output signal, mode, invert_n, clear_n,
                  input  clk_rec, bit_period, locked, data_out, data_valid, glitch_cnt);
  modport slave  (input  signal, mode, invert_n, clear_n,
                  output clk_rec, bit_period, locked, data_out, data_valid, glitch_cnt);
endinterface

// File: rtl/sig_edge_sync.sv
// sig_edge_sync: STAGES-deep synchroniser plus change detector
// clk/rst: clock and async active-high reset; din: asynchronous input
// sync_q: synchronised level; edge_det: sync_q differs from its previous value
// IDLE is the reset level of every flop, so idle-high keys report no edge out of reset
module sig_edge_sync #(
  parameter int   STAGES = 2,
  parameter logic IDLE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_q,
  output logic edge_det
);
  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q;
  always_comb begin
    chain_d  = (chain_q << 1) | STAGES'(din);
    sync_q   = chain_q[STAGES-1];
    edge_det = sync_q != prev_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      chain_q <= {STAGES{IDLE}};
      prev_q  <= IDLE;
    end else begin
      chain_q <= chain_d;
      prev_q  <= sync_q;
    end
endmodule

// File: rtl/bit_clock_recovery_v2.sv
// bit_clock_recovery_v2: min-interval bit period tracker with recovered clock and mid-bit sampler
// clk_300M/rst: base clock and async active-high reset
// bus (slave): signal/mode/invert_n/clear_n in; clk_rec, bit_period, locked,
// data_out, data_valid, glitch_cnt out
module bit_clock_recovery_v2 import cdr_pkg::*; #(
  parameter int CNT_LEN       = CNT_LEN_DEF,
  parameter int STABLE_LEN    = STABLE_LEN_DEF,
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_PERIOD    = 4,
  parameter int INIT_PERIOD   = 801,
  parameter int LOCK_EDGES    = 16,
  parameter int TIMEOUT_SHIFT = 4
) (
  input logic clk_300M,
  input logic rst,
  bit_clock_recovery_v2_if.slave bus
);
  localparam int                 LW       = $clog2(LOCK_EDGES + 1);
  localparam logic [CNT_LEN-1:0] CNT_MAX  = '1;
  localparam logic [CNT_LEN-1:0] MIN_P    = CNT_LEN'(MIN_PERIOD);
  localparam logic [CNT_LEN-1:0] INIT_P   = CNT_LEN'(INIT_PERIOD);
  localparam logic [LW-1:0]      LOCK_MAX = LW'(LOCK_EDGES);
  logic                  sync_q, sig_edge, inv_lvl, inv_edge, clr_lvl, clr_edge;
  logic                  clr, glitch, valid, wrap;
  logic [CNT_LEN-1:0]    span, tmo_lim, half;
  logic [CNT_LEN-1:0]    interval_q, interval_d, bit_period_q, bit_period_d, bit_cnt_q, bit_cnt_d;
  logic [STABLE_LEN-1:0] stable_cnt_q, stable_cnt_d;
  logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
  logic [GLITCH_W-1:0]   glitch_cnt_q, glitch_cnt_d;
  logic                  locked_q, locked_d, clk_rec_q, clk_rec_d, tgl_q, tgl_d;
  logic                  data_out_q, data_out_d, data_valid_q, data_valid_d, phase_inv_q, phase_inv_d;
  sig_edge_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sig (
    .clk(clk_300M), .rst(rst), .din(bus.signal), .sync_q(sync_q), .edge_det(sig_edge));
  sig_edge_sync #(.STAGES(1), .IDLE(1'b1)) u_inv (
    .clk(clk_300M), .rst(rst), .din(bus.invert_n), .sync_q(inv_lvl), .edge_det(inv_edge));
  sig_edge_sync #(.STAGES(1), .IDLE(1'b1)) u_clr (
    .clk(clk_300M), .rst(rst), .din(bus.clear_n), .sync_q(clr_lvl), .edge_det(clr_edge));
  always_comb begin
    // interval_q holds elapsed cycles minus one, so span is the true edge-to-edge distance
    span         = (interval_q == CNT_MAX) ? interval_q : interval_q + 1'b1;
    tmo_lim      = ((bit_period_q >> (CNT_LEN - TIMEOUT_SHIFT)) != '0) ? CNT_MAX : bit_period_q << TIMEOUT_SHIFT;
    half         = bit_period_q >> 1;
    clr          = clr_edge & ~clr_lvl;
    glitch       = sig_edge & (span < MIN_P);
    valid        = sig_edge & ~glitch;
    wrap         = valid || (bit_cnt_q >= bit_period_q - 1'b1);
    interval_d   = valid ? '0 : span;
    bit_period_d = bit_period_q;
    stable_cnt_d = stable_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    locked_d     = locked_q;
    if (valid && span < bit_period_q) begin
      bit_period_d = span;
      stable_cnt_d = '0;
      lock_cnt_d   = '0;
      locked_d     = 1'b0;
    end else if (valid) begin
      stable_cnt_d = stable_cnt_q + 1'b1;
      lock_cnt_d   = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
      // a long run of edges never shorter than the estimate lets the period creep up by one
      if (&stable_cnt_d) begin
        bit_period_d = (bit_period_q == CNT_MAX) ? bit_period_q : bit_period_q + 1'b1;
        stable_cnt_d = '0;
      end
      if (lock_cnt_d == LOCK_MAX) locked_d = 1'b1;
    end else if (span >= tmo_lim) begin
      locked_d   = 1'b0;
      lock_cnt_d = '0;
    end
    bit_cnt_d    = wrap ? '0 : bit_cnt_q + 1'b1;
    tgl_d        = tgl_q ^ wrap;
    clk_rec_d    = ((mode_e'(bus.mode) == MODE_FULL) ? tgl_d : (bit_cnt_d >= half)) ^ phase_inv_q;
    data_valid_d = locked_q && (bit_cnt_d == half);
    data_out_d   = data_valid_d ? sync_q : data_out_q;
    glitch_cnt_d = (glitch && !(&glitch_cnt_q)) ? glitch_cnt_q + 1'b1 : glitch_cnt_q;
    phase_inv_d  = phase_inv_q ^ (inv_edge & ~inv_lvl);
    // re-acquire restarts tracking but keeps the glitch tally and phase choice
    if (clr) begin
      interval_d   = '0;
      bit_period_d = INIT_P;
      stable_cnt_d = '0;
      lock_cnt_d   = '0;
      locked_d     = 1'b0;
      bit_cnt_d    = '0;
      tgl_d        = 1'b0;
      clk_rec_d    = 1'b0;
      data_valid_d = 1'b0;
      data_out_d   = 1'b0;
    end
  end
  always_ff @(posedge clk_300M or posedge rst)
    if (rst) begin
      interval_q   <= '0;
      bit_period_q <= INIT_P;
      bit_cnt_q    <= '0;
      stable_cnt_q <= '0;
      lock_cnt_q   <= '0;
      glitch_cnt_q <= '0;
      locked_q     <= 1'b0;
      clk_rec_q    <= 1'b0;
      tgl_q        <= 1'b0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      phase_inv_q  <= 1'b0;
    end else begin
      interval_q   <= interval_d;
      bit_period_q <= bit_period_d;
      bit_cnt_q    <= bit_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
      locked_q     <= locked_d;
      clk_rec_q    <= clk_rec_d;
      tgl_q        <= tgl_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      phase_inv_q  <= phase_inv_d;
    end
  assign bus.clk_rec    = clk_rec_q;
  assign bus.bit_period = bit_period_q;
  assign bus.locked     = locked_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.glitch_cnt = glitch_cnt_q;
endmodule

// File: tb/tb_bit_clock_recovery_v2.sv
// tb_bit_clock_recovery_v2: directed checks of period acquisition, glitch, creep, timeout, mode, invert, clear and reset
module tb_bit_clock_recovery_v2;
  import cdr_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0, n_err = 0, stab = 0;
  int   hi, dvn, d, p;
  bit_clock_recovery_v2_if #(.CNT_LEN(32)) bus ();
  bit_clock_recovery_v2 dut (.clk_300M(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tog(input bit qual);
    bus.signal = ~bus.signal;
    if (qual) stab++;
  endtask
  task automatic wait_rise(output int n);
    logic pv;
    n  = 0;
    pv = bus.clk_rec;
    while (n < 200) begin
      cyc(1);
      n++;
      if (!pv && bus.clk_rec) break;
      pv = bus.clk_rec;
    end
  endtask
  task automatic meas(output int per);
    int w;
    wait_rise(w);
    wait_rise(per);
  endtask
  task automatic acquire(input string tag);
    cyc(40);
    tog(0);
    cyc(30);
    tog(0);
    cyc(30);
    chk({tag, "_period30"}, bus.bit_period, 30);
    chk({tag, "_unlocked"}, bus.locked, 0);
    stab = 0;
    for (int i = 1; i <= 16; i++) begin
      tog(1);
      cyc(30);
      if (i == 15) chk({tag, "_unlocked15"}, bus.locked, 0);
    end
    chk({tag, "_locked16"}, bus.locked, 1);
  endtask
  initial begin
    bus.signal   = 1'b0;
    bus.mode     = MODE_HALF;
    bus.invert_n = 1'b1;
    bus.clear_n  = 1'b1;
    cyc(3);
    chk("rst_period", bus.bit_period, 801);
    chk("rst_locked", bus.locked, 0);
    chk("rst_clk", bus.clk_rec, 0);
    chk("rst_dv", bus.data_valid, 0);
    chk("rst_glitch", bus.glitch_cnt, 0);
    rst = 1'b0;
    cyc(2);
    acquire("acq");
    hi  = 0;
    dvn = 0;
    tog(1);
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      hi  += int'(bus.clk_rec);
      dvn += int'(bus.data_valid);
      if (k == 3) chk("align_clk_low", bus.clk_rec, 0);
      if (k == 18) begin
        chk("mid_dv", bus.data_valid, 1);
        chk("mid_clk_rise", bus.clk_rec, 1);
        chk("mid_data", bus.data_out, bus.signal);
      end
    end
    chk("clk_high_cycles", hi, 15);
    chk("dv_per_bit", dvn, 1);
    tog(1);
    cyc(2);
    tog(0);
    cyc(28);
    chk("glitch_cnt", bus.glitch_cnt, 1);
    chk("glitch_period", bus.bit_period, 30);
    chk("glitch_locked", bus.locked, 1);
    while (stab < 254) begin
      tog(1);
      cyc(31);
    end
    chk("creep_pre", bus.bit_period, 30);
    tog(1);
    cyc(31);
    chk("creep_post", bus.bit_period, 31);
    chk("creep_locked", bus.locked, 1);
    bus.clear_n = 1'b0;
    cyc(3);
    bus.clear_n = 1'b1;
    chk("clr_period", bus.bit_period, 801);
    chk("clr_locked", bus.locked, 0);
    chk("clr_glitch_kept", bus.glitch_cnt, 1);
    chk("clr_clk", bus.clk_rec, 0);
    acquire("reacq");
    tog(1);
    cyc(482);
    chk("tmo_before", bus.locked, 1);
    cyc(1);
    chk("tmo_drop", bus.locked, 0);
    chk("tmo_period", bus.bit_period, 30);
    meas(p);
    chk("tmo_clk_period", p, 30);
    bus.mode = MODE_FULL;
    cyc(5);
    meas(p);
    chk("mode1_period", p, 60);
    bus.mode = MODE_HALF;
    cyc(5);
    wait_rise(d);
    chk("inv_rise_seen", d < 200, 1);
    bus.invert_n = 1'b0;
    cyc(2);
    chk("inv_pre", bus.clk_rec, 1);
    cyc(1);
    chk("inv_flip", bus.clk_rec, 0);
    bus.invert_n = 1'b1;
    cyc(13);
    chk("inv_low_half", bus.clk_rec, 1);
    for (int i = 1; i <= 16; i++) begin
      tog(1);
      cyc(30);
      if (i == 15) chk("relock15", bus.locked, 0);
    end
    chk("relock16", bus.locked, 1);
    d = 0;
    while (!(bus.clk_rec && bus.locked) && d < 100) begin
      cyc(1);
      d++;
    end
    chk("rst_pre_state", bus.clk_rec && bus.locked, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_clk", bus.clk_rec, 0);
    chk("arst_locked", bus.locked, 0);
    chk("arst_period", bus.bit_period, 801);
    chk("arst_glitch", bus.glitch_cnt, 0);
    chk("arst_data", bus.data_out, 0);
    repeat (3) @(negedge clk);
    chk("arst_hold_period", bus.bit_period, 801);
    chk("arst_hold_clk", bus.clk_rec, 0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
